// File: rtl/prv32_div_seq.sv
// prv32_div_seq: sequential radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Define PRV32_DIV_EARLY_OUT_EN to finish divide-by-zero, signed overflow and unsigned a<b in one cycle.
module prv32_div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        kill,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  Function3,
  output logic        busy,
  output logic        done,
  output logic [31:0] r
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [5:0] cnt;
  logic [31:0] dvd, dvs, rem, rem_n, dvd_n, abs_a, abs_b, q_fix, rm_fix, eo_r;
  logic [32:0] rem_sh;
  logic neg_q, neg_r, op_rem, b_zero, sgn, accept, ge, eo;
  always_comb begin
    sgn = ~Function3[0];
    abs_a = (sgn & a[31]) ? -a : a;
    abs_b = (sgn & b[31]) ? -b : b;
    accept = (state == IDLE) & start & Function3[2] & ~kill;
    rem_sh = {rem, dvd[31]};
    ge = rem_sh >= {1'b0, dvs};
    // a successful subtract always leaves less than dvs, so the low 32 bits suffice
    rem_n = ge ? rem_sh[31:0] - dvs : rem_sh[31:0];
    dvd_n = {dvd[30:0], ge};
    q_fix = b_zero ? '1 : neg_q ? -dvd : dvd;
    rm_fix = neg_r ? -rem : rem;
`ifdef PRV32_DIV_EARLY_OUT_EN
    eo = accept & ((b == 32'd0) | (sgn & (a == 32'h8000_0000) & (&b)) | (~sgn & (a < b)));
    eo_r = (b == 32'd0) ? (Function3[1] ? a : '1) : sgn ? (Function3[1] ? '0 : a) : (Function3[1] ? a : '0);
`else
    eo = 1'b0;
    eo_r = '0;
`endif
    state_n = kill ? IDLE : accept ? (eo ? DONE : CALC) : (state == CALC) ? ((cnt == 6'd32) ? DONE : CALC) : IDLE;
    busy = state != IDLE;
    done = (state == DONE) & ~kill;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      op_rem <= 1'b0;
      b_zero <= 1'b0;
      r <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        cnt <= '0;
        dvd <= abs_a;
        dvs <= abs_b;
        rem <= '0;
        neg_q <= sgn & (a[31] ^ b[31]);
        neg_r <= sgn & a[31];
        op_rem <= Function3[1];
        b_zero <= b == 32'd0;
        if (eo) r <= eo_r;
      end else if (state == CALC) begin
        if (cnt != 6'd32) begin
          cnt <= cnt + 6'd1;
          dvd <= dvd_n;
          rem <= rem_n;
        end else if (~kill) r <= op_rem ? rm_fix : q_fix;
      end
    end
  end
endmodule
